stage_mem: RTL and testbench
============================

# stage_mem

Memory-access stage between the EX/MEM register and the writeback stage. Issues load/store requests to data memory over a req/ready handshake, generates store byte enables and lane-replicated write data, detects misaligned accesses, stalls the pipeline on wait states, and registers the MEM/WB pipeline state. Load data is passed through as the raw aligned word; writeback performs byte/half selection and extension from `wb_alu_o[1:0]` and `wb_func3_code`.

## Interface
- `TIMEOUT_CYCLES`, 16: wait-state limit before abort. Used only with `MEM_TIMEOUT_EN`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `me_valid` in 1: instruction present in MEM.
- `me_alu_o` in 32: effective address or ALU result.
- `me_regs_data2` in 32: store source (rs2).
- `me_mem_read`, `me_mem_write` in 1 each: load / store.
- `me_mem2reg`, `me_regwrite` in 1 each: writeback controls.
- `me_func3_code` in 3: LB/LH/LW/LBU/LHU, SB/SH/SW.
- `me_rd` in 5: destination register.
- `dmem_req` out 1: request.
- `dmem_we` out 1: write.
- `dmem_addr` out 32: word address, `{me_alu_o[31:2],2'b00}`.
- `dmem_wdata` out 32: lane-replicated write data.
- `dmem_be` out 4: byte enables.
- `dmem_ready` in 1: request accepted and completed this cycle.
- `dmem_rdata` in 32: read word, valid when `dmem_ready`.
- `mem_stall` out 1: hold all upstream stages.
- `mem_misalign` out 1: one-cycle misaligned-access pulse.
- `mem_bus_err` out 1: one-cycle timeout pulse; constant 0 without `MEM_TIMEOUT_EN`.
- `wb_valid`, `wb_mem2reg`, `wb_regwrite` out 1 each.
- `wb_mem_data`, `wb_alu_o` out 32 each.
- `wb_func3_code` out 3.
- `wb_rd` out 5.

## Operation
- Access = `me_valid & (me_mem_read | me_mem_write)`.
- Misaligned:
  - Half access (func3[1:0]=01) with `addr[0]`=1.
  - Word access (func3[1:0]=10) with `addr[1:0]`≠0.
  - Misaligned access: no request, `mem_misalign`=1 for one cycle, MEM/WB loads a bubble (`wb_valid`=`wb_regwrite`=`wb_mem2reg`=0).
- Store lanes:
  - SB: `be`=`4'b0001<<addr[1:0]`, `wdata`=`{4{rs2[7:0]}}`.
  - SH: `be`=0011 if `addr[1]`=0, else 1100; `wdata`=`{2{rs2[15:0]}}`.
  - SW: `be`=1111, `wdata`=rs2.
  - Loads drive `be`=1111, `we`=0.
- FSM states IDLE and WAIT:
  - IDLE, aligned access: `dmem_req`=1 combinationally. If `dmem_ready`=1, MEM/WB loads at the edge and the FSM stays in IDLE. Otherwise `mem_stall`=1 and the next state is WAIT.
  - WAIT: `dmem_req` held, `mem_stall`=1. On `dmem_ready`=1, MEM/WB loads and the next state is IDLE.
- Upstream holds all `me_*` inputs stable while `mem_stall`=1. `dmem_addr`, `dmem_wdata`, `dmem_be`, and `dmem_we` are therefore stable for the whole request.
- Non-memory instruction or bubble: no request, no stall. MEM/WB loads every cycle.
- MEM/WB register:
  - Loads when `mem_stall`=0.
  - `wb_mem_data` = `dmem_rdata` for loads, 0 otherwise.
  - All other `wb_*` outputs copy the corresponding `me_*` inputs.
  - While stalled, the register holds its previous contents and `wb_valid` is forced to 0 (bubble into WB), so a held instruction never writes back twice.

## Timing
- Reset: every output 0, FSM in IDLE. Asserting `rst` during WAIT drops `dmem_req` immediately (asynchronously); the pending access is abandoned.
- Zero-wait memory: 1-cycle latency from MEM to WB-register valid, identical to ALU instructions.
- N wait cycles: `mem_stall` high for N cycles; writeback valid on cycle N+1.
- `mem_stall` is combinational: `req & ~dmem_ready`.
- `dmem_ready` with no request is ignored.
- A store completes in the `dmem_ready` cycle. It reaches WB with `wb_regwrite`=0 as decoded upstream.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A counter runs in WAIT.
  - If `dmem_ready` is still 0 after `TIMEOUT_CYCLES` wait cycles: drop `req`, pulse `mem_bus_err`, load a bubble into MEM/WB, return to IDLE, release the stall.
  - The counter clears on IDLE entry and on reset.
- `MEM_TIMEOUT_EN` undefined: no counter, WAIT is held indefinitely, `mem_bus_err` tied 0.

## Test plan
- LW, addr 0x100, `dmem_ready` same cycle, rdata 0xDEADBEEF -> next cycle `wb_valid`=1, `wb_mem_data`=0xDEADBEEF, `wb_alu_o`=0x100, `mem_stall` never asserted.
- SB, addr 0x103, rs2=0x000000A5 -> `dmem_be`=1000, `dmem_wdata`=0xA5A5A5A5, `dmem_addr`=0x100, `dmem_we`=1.
- SH, addr 0x102, rs2=0x1234 -> `be`=1100, `wdata`=0x12341234. LH at 0x101 -> `mem_misalign` pulse, `dmem_req`=0, WB bubble.
- LBU, addr 0x204, `dmem_ready` delayed 3 cycles -> `mem_stall` high 3 cycles, `wb_valid`=0 during the stall, then `wb_valid`=1 with rdata and `wb_func3_code`=100.
- Assert `rst` in WAIT -> `dmem_req` and all `wb_*` outputs 0 immediately; the next access proceeds normally.
- With `MEM_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, `dmem_ready` held 0 -> `mem_bus_err` pulses after 16 wait cycles, stall released, WB bubble.

Source files
------------

// File: rtl/stage_mem.sv
// stage_mem: memory-access pipeline stage.
// Issues data-memory requests over a req/ready handshake. Generates store byte enables and
// lane-replicated write data. Flags misaligned accesses and stalls upstream while the memory
// inserts wait states. Registers the MEM/WB pipeline state; load data is passed through as
// the raw aligned word, and writeback does byte/half selection.
//
// Optional feature: define MEM_TIMEOUT_EN to abort a request after TIMEOUT_CYCLES wait
// cycles. The abort pulses mem_bus_err and sends a bubble to WB.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   me_*                     EX/MEM register contents (held stable by upstream while stalled)
//   dmem_req/we/addr/wdata/be  request to data memory
//   dmem_ready, dmem_rdata   completion and read word from data memory
//   mem_stall                hold all upstream stages
//   mem_misalign             misaligned access (no request issued)
//   mem_bus_err              wait-state timeout (always 0 unless MEM_TIMEOUT_EN)
//   wb_*                     MEM/WB register outputs
module stage_mem #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        me_valid,
    input  logic [31:0] me_alu_o,
    input  logic [31:0] me_regs_data2,
    input  logic        me_mem_read,
    input  logic        me_mem_write,
    input  logic        me_mem2reg,
    input  logic        me_regwrite,
    input  logic [2:0]  me_func3_code,
    input  logic [4:0]  me_rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        mem_misalign,
    output logic        mem_bus_err,
    output logic        wb_valid,
    output logic        wb_mem2reg,
    output logic        wb_regwrite,
    output logic [31:0] wb_mem_data,
    output logic [31:0] wb_alu_o,
    output logic [2:0]  wb_func3_code,
    output logic [4:0]  wb_rd
);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e      state_q, state_d;
    logic        access;
    logic        misalign;
    logic        timeout;
    logic        req;
    logic        bubble;
    logic [3:0]  be;
    logic [31:0] wdata;

    assign access   = me_valid & (me_mem_read | me_mem_write);
    assign misalign = access & (((me_func3_code[1:0] == 2'b01) & me_alu_o[0]) |
                                ((me_func3_code[1:0] == 2'b10) & (|me_alu_o[1:0])));

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q;

    // Counts stall cycles of the current request; the first one is spent in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_d == StIdle) begin
            cnt_q <= '0;
        end else if (mem_stall) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign timeout = (state_q == StWait) && (cnt_q == CntW'(TIMEOUT_CYCLES));
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (access && !misalign) begin
                    req = 1'b1;
                    if (!dmem_ready) state_d = StWait;
                end
            end
            StWait: begin
                // me_* are held by upstream, so the request stays valid without re-decoding.
                if (timeout) begin
                    state_d = StIdle;
                end else begin
                    req = 1'b1;
                    if (dmem_ready) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Store lane steering; loads enable every byte of the word.
    always_comb begin
        be    = 4'b0000;
        wdata = me_regs_data2;
        if (access) begin
            be = 4'b1111;
            if (me_mem_write) begin
                unique case (me_func3_code[1:0])
                    2'b00: begin
                        be    = 4'b0001 << me_alu_o[1:0];
                        wdata = {4{me_regs_data2[7:0]}};
                    end
                    2'b01: begin
                        be    = me_alu_o[1] ? 4'b1100 : 4'b0011;
                        wdata = {2{me_regs_data2[15:0]}};
                    end
                    default: be = 4'b1111;
                endcase
            end
        end
    end

    // Reset gates the combinational outputs so a pending request drops immediately.
    assign dmem_req     = req & ~rst;
    assign dmem_we      = dmem_req & me_mem_write;
    assign dmem_addr    = rst ? 32'd0 : {me_alu_o[31:2], 2'b00};
    assign dmem_wdata   = rst ? 32'd0 : wdata;
    assign dmem_be      = rst ? 4'd0 : be;
    assign mem_stall    = dmem_req & ~dmem_ready;
    assign mem_misalign = misalign & ~rst;
    assign mem_bus_err  = timeout & ~rst;

    assign bubble = misalign | timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid      <= 1'b0;
            wb_mem2reg    <= 1'b0;
            wb_regwrite   <= 1'b0;
            wb_mem_data   <= 32'd0;
            wb_alu_o      <= 32'd0;
            wb_func3_code <= 3'd0;
            wb_rd         <= 5'd0;
        end else if (mem_stall) begin
            // Held instruction must not write back twice.
            wb_valid <= 1'b0;
        end else begin
            wb_valid      <= me_valid & ~bubble;
            wb_mem2reg    <= me_mem2reg & ~bubble;
            wb_regwrite   <= me_regwrite & ~bubble;
            wb_mem_data   <= (req & me_mem_read) ? dmem_rdata : 32'd0;
            wb_alu_o      <= me_alu_o;
            wb_func3_code <= me_func3_code;
            wb_rd         <= me_rd;
        end
    end

endmodule

// File: tb/tb_stage_mem.sv
module tb_stage_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        me_valid;
    logic [31:0] me_alu_o;
    logic [31:0] me_regs_data2;
    logic        me_mem_read;
    logic        me_mem_write;
    logic        me_mem2reg;
    logic        me_regwrite;
    logic [2:0]  me_func3_code;
    logic [4:0]  me_rd;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic        mem_misalign;
    logic        mem_bus_err;
    logic        wb_valid;
    logic        wb_mem2reg;
    logic        wb_regwrite;
    logic [31:0] wb_mem_data;
    logic [31:0] wb_alu_o;
    logic [2:0]  wb_func3_code;
    logic [4:0]  wb_rd;

    int vectors = 0;
    int miscompares = 0;

    stage_mem #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .me_valid(me_valid), .me_alu_o(me_alu_o), .me_regs_data2(me_regs_data2),
        .me_mem_read(me_mem_read), .me_mem_write(me_mem_write),
        .me_mem2reg(me_mem2reg), .me_regwrite(me_regwrite),
        .me_func3_code(me_func3_code), .me_rd(me_rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .mem_misalign(mem_misalign), .mem_bus_err(mem_bus_err),
        .wb_valid(wb_valid), .wb_mem2reg(wb_mem2reg), .wb_regwrite(wb_regwrite),
        .wb_mem_data(wb_mem_data), .wb_alu_o(wb_alu_o),
        .wb_func3_code(wb_func3_code), .wb_rd(wb_rd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected bus fields derived from the access size and byte offset with plain arithmetic.
    task automatic check_bus(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b);
        int unsigned off;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
        off = a % 4;
        e_wdata = b;
        e_be = 4'd15;
        if (wr && f3[1:0] == 2'd0) begin
            e_be = 4'(1 << off);
            e_wdata = (b % 256) * 32'h0101_0101;
        end else if (wr && f3[1:0] == 2'd1) begin
            e_be = (off >= 2) ? 4'd12 : 4'd3;
            e_wdata = (b % 65536) * 32'h0001_0001;
        end
        check("dmem_addr", dmem_addr, a - off);
        check("dmem_we", dmem_we, wr);
        check("dmem_be", dmem_be, e_be);
        check("dmem_wdata", dmem_wdata, e_wdata);
    endtask

    // One instruction through MEM; entered and left just after a rising edge.
    task automatic run_instr(input logic v, input logic rdf, input logic wrf, input logic m2r,
                             input logic rw, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] rdst, input int nwait,
                             input logic [31:0] rdat);
        logic acc, mis, go;
        acc = v && (rdf || wrf);
        mis = acc && ((f3[1:0] == 2'd1 && a % 2 != 0) || (f3[1:0] == 2'd2 && a % 4 != 0));
        go  = acc && !mis;
        me_valid = v; me_mem_read = rdf; me_mem_write = wrf; me_mem2reg = m2r;
        me_regwrite = rw; me_func3_code = f3; me_alu_o = a; me_regs_data2 = b; me_rd = rdst;
        dmem_rdata = $urandom;
        dmem_ready = go ? (nwait == 0) : 1'($urandom % 2);
        if (go) begin
            for (int k = 0; k < nwait; k++) begin
                @(negedge clk);
                check("wait_req", dmem_req, 1'b1);
                check("wait_stall", mem_stall, 1'b1);
                check("wait_misalign", mem_misalign, 1'b0);
                check("wait_bus_err", mem_bus_err, 1'b0);
                if (k > 0) check("wait_wb_valid", wb_valid, 1'b0);
                check_bus(wrf, f3, a, b);
                @(posedge clk); #1;
            end
            dmem_ready = 1'b1;
            dmem_rdata = rdat;
        end
        @(negedge clk);
        check("req", dmem_req, go);
        check("stall", mem_stall, 1'b0);
        check("misalign", mem_misalign, mis);
        check("bus_err", mem_bus_err, 1'b0);
        if (go) check_bus(wrf, f3, a, b);
        @(posedge clk); #1;
        check("wb_valid", wb_valid, v && !mis);
        check("wb_regwrite", wb_regwrite, rw && !mis);
        check("wb_mem2reg", wb_mem2reg, m2r && !mis);
        check("wb_mem_data", wb_mem_data, (go && rdf) ? rdat : 32'd0);
        check("wb_alu_o", wb_alu_o, a);
        check("wb_func3", wb_func3_code, f3);
        check("wb_rd", wb_rd, rdst);
        dmem_ready = 1'b0;
    endtask

    initial begin
        logic [2:0] ld_f3 [5];
        logic [2:0] st_f3 [3];
        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        st_f3 = '{3'd0, 3'd1, 3'd2};
        rst = 1'b1;
        me_valid = 0; me_alu_o = 0; me_regs_data2 = 0; me_mem_read = 0; me_mem_write = 0;
        me_mem2reg = 0; me_regwrite = 0; me_func3_code = 0; me_rd = 0;
        dmem_ready = 0; dmem_rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", dmem_req, 1'b0);
        check("rst_stall", mem_stall, 1'b0);
        check("rst_be", dmem_be, 4'd0);
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_wb_data", wb_mem_data, 32'd0);
        check("rst_wb_alu", wb_alu_o, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // LW zero-wait, SB, SH, misaligned LH, LBU with three wait states, ALU op.
        run_instr(1, 1, 0, 1, 1, 3'b010, 32'h100, 32'h0, 5'd3, 0, 32'hDEAD_BEEF);
        run_instr(1, 0, 1, 0, 0, 3'b000, 32'h103, 32'hA5, 5'd0, 0, 32'h0);
        run_instr(1, 0, 1, 0, 0, 3'b001, 32'h102, 32'h1234, 5'd0, 1, 32'h0);
        run_instr(1, 1, 0, 1, 1, 3'b001, 32'h101, 32'h0, 5'd7, 0, 32'h0);
        run_instr(1, 1, 0, 1, 1, 3'b100, 32'h204, 32'h0, 5'd9, 3, 32'h1122_3344);
        run_instr(1, 0, 0, 0, 1, 3'b111, 32'h55AA, 32'h0, 5'd4, 0, 32'h0);

        // Reset while waiting drops the request and clears WB at once.
        me_valid = 1; me_mem_read = 1; me_mem_write = 0; me_mem2reg = 1; me_regwrite = 1;
        me_func3_code = 3'b010; me_alu_o = 32'h300; me_rd = 5'd12; dmem_ready = 0;
        @(negedge clk);
        check("pre_rst_stall", mem_stall, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        check("pre_rst_req", dmem_req, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("rst_wait_req", dmem_req, 1'b0);
        check("rst_wait_stall", mem_stall, 1'b0);
        check("rst_wait_wb_alu", wb_alu_o, 32'd0);
        check("rst_wait_wb_rd", wb_rd, 5'd0);
        check("rst_wait_wb_func3", wb_func3_code, 3'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_instr(1, 1, 0, 1, 1, 3'b010, 32'h300, 32'h0, 5'd12, 2, 32'hCAFE_F00D);

        for (int i = 0; i < 300; i++) begin
            int kind;
            logic v;
            kind = int'($urandom % 3);
            v = ($urandom % 8) != 0;
            if (kind == 0) begin
                run_instr(v, 1, 0, 1, 1, ld_f3[$urandom % 5], $urandom, $urandom,
                          5'($urandom), int'($urandom % 5), $urandom);
            end else if (kind == 1) begin
                run_instr(v, 0, 1, 0, 0, st_f3[$urandom % 3], $urandom, $urandom,
                          5'($urandom), int'($urandom % 5), $urandom);
            end else begin
                run_instr(v, 0, 0, 0, 1'($urandom), 3'($urandom), $urandom, $urandom,
                          5'($urandom), 0, $urandom);
            end
        end

`ifdef MEM_TIMEOUT_EN
        // Memory never answers: 16 stall cycles, then an abort cycle.
        me_valid = 1; me_mem_read = 1; me_mem_write = 0; me_mem2reg = 1; me_regwrite = 1;
        me_func3_code = 3'b010; me_alu_o = 32'h400; me_rd = 5'd5; dmem_ready = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("to_stall", mem_stall, 1'b1);
            check("to_bus_err_early", mem_bus_err, 1'b0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("to_bus_err", mem_bus_err, 1'b1);
        check("to_req", dmem_req, 1'b0);
        check("to_stall_rel", mem_stall, 1'b0);
        @(posedge clk); #1;
        check("to_wb_valid", wb_valid, 1'b0);
        check("to_wb_regwrite", wb_regwrite, 1'b0);
        me_valid = 0; me_mem_read = 0;
        @(negedge clk);
        check("to_bus_err_clear", mem_bus_err, 1'b0);
        @(posedge clk); #1;
        run_instr(1, 1, 0, 1, 1, 3'b010, 32'h404, 32'h0, 5'd6, 1, 32'h0BAD_CAFE);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
